// File: rtl/timer_counter_core.sv
// Timer counter core: prescaler, free-run/one-shot/up-down counter, sticky match and overflow flags.
// Optional input capture is compiled in with `define TIMER_CAPTURE_EN.
module timer_counter_core #(
    parameter int NUM_COMP = 3,
    parameter int CNT_W    = 8,
    parameter int PSC_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [1:0]                     mode,
    input  logic                           start,
    input  logic [CNT_W-1:0]               period,
    input  logic [PSC_W-1:0]               prescale,
    input  logic [NUM_COMP-1:0][CNT_W-1:0] match_value,
    input  logic [NUM_COMP-1:0]            flag_clr,
    input  logic                           ovf_clr,
`ifdef TIMER_CAPTURE_EN
    input  logic                           cap_in,
    input  logic                           cap_clr,
    output logic [CNT_W-1:0]               cap_value,
    output logic                           cap_flag,
`endif
    output logic [CNT_W-1:0]               counter_value,
    output logic [NUM_COMP-1:0]            flag,
    output logic                           ovf_flag,
    output logic                           tick,
    output logic                           running
);

    localparam logic [1:0] MODE_FREE = 2'b00;
    localparam logic [1:0] MODE_ONE  = 2'b01;
    localparam logic [1:0] MODE_UPDN = 2'b10;

    logic [1:0]          mode_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PSC_W-1:0]    psc_q, psc_d;
    logic                dir_q, dir_d;
    logic                armed_q, armed_d;
    logic [NUM_COMP-1:0] flag_q, flag_d, match_set;
    logic                ovf_q, ovf_d, ovf_evt;
    logic                tick_q;
    logic                mode_chg, run, step, go_down;

    assign mode_chg = (mode != mode_q);
    assign run      = en & ((mode_q == MODE_FREE) | (mode_q == MODE_UPDN) |
                            ((mode_q == MODE_ONE) & armed_q));
    assign step     = run & ~mode_chg & (psc_q == prescale);

    always_comb begin
        cnt_d   = cnt_q;
        psc_d   = psc_q;
        dir_d   = dir_q;
        armed_d = armed_q;
        ovf_evt = 1'b0;
        go_down = 1'b0;
        if (mode_chg) begin
            cnt_d   = '0;
            psc_d   = '0;
            dir_d   = 1'b0;
            armed_d = 1'b0;
        end else begin
            if (run) begin
                psc_d = (psc_q == prescale) ? '0 : psc_q + 1'b1;
            end
            if ((mode_q == MODE_ONE) && en && start && !armed_q) begin
                armed_d = 1'b1;
            end
            if (step) begin
                if (mode_q == MODE_UPDN) begin
                    if (period == '0) begin
                        cnt_d   = '0;
                        dir_d   = 1'b0;
                        ovf_evt = 1'b1;
                    end else begin
                        // dir_q holds the direction of the next step; turnaround is decided on arrival
                        go_down = (dir_q && cnt_q != '0) || (!dir_q && cnt_q == period);
                        if (go_down) begin
                            cnt_d = cnt_q - 1'b1;
                            if (cnt_d == '0) begin
                                dir_d   = 1'b0;
                                ovf_evt = 1'b1;
                            end else begin
                                dir_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            dir_d = (cnt_d == period);
                        end
                    end
                end else if (cnt_q == period) begin
                    cnt_d   = '0;
                    ovf_evt = 1'b1;
                    if (mode_q == MODE_ONE) begin
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        match_set = '0;
        for (int i = 0; i < NUM_COMP; i++) begin
            match_set[i] = step & (cnt_d == match_value[i]);
        end
        flag_d = (flag_q & ~flag_clr) | match_set;
        ovf_d  = (ovf_q & ~ovf_clr) | ovf_evt;
    end

    always_ff @(posedge clk) begin
        mode_q <= mode;
        if (!rst) begin
            cnt_q   <= '0;
            psc_q   <= '0;
            dir_q   <= 1'b0;
            armed_q <= 1'b0;
            flag_q  <= '0;
            ovf_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            psc_q   <= psc_d;
            dir_q   <= dir_d;
            armed_q <= armed_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            tick_q  <= step;
        end
    end

    assign counter_value = cnt_q;
    assign flag          = flag_q;
    assign ovf_flag      = ovf_q;
    assign tick          = tick_q;
    // Masked while reset is held so the block reports idle during reset
    assign running       = rst & run;

`ifdef TIMER_CAPTURE_EN
    logic [2:0]       cap_sync_q;
    logic [CNT_W-1:0] cap_value_q;
    logic             cap_flag_q;
    logic             cap_edge;

    assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_sync_q  <= '0;
            cap_value_q <= '0;
            cap_flag_q  <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], cap_in};
            if (cap_edge) begin
                cap_value_q <= cnt_q;
                cap_flag_q  <= 1'b1;
            end else if (cap_clr) begin
                cap_flag_q <= 1'b0;
            end
        end
    end

    assign cap_value = cap_value_q;
    assign cap_flag  = cap_flag_q;
`endif

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed self-checking bench for timer_counter_core (capture checks built with TIMER_CAPTURE_EN).
module tb_timer_counter_core;

    localparam int NUM_COMP = 3;
    localparam int CNT_W    = 8;
    localparam int PSC_W    = 8;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           en;
    logic [1:0]                     mode;
    logic                           start;
    logic [CNT_W-1:0]               period;
    logic [PSC_W-1:0]               prescale;
    logic [NUM_COMP-1:0][CNT_W-1:0] match_value;
    logic [NUM_COMP-1:0]            flag_clr;
    logic                           ovf_clr;
    logic [CNT_W-1:0]               counter_value;
    logic [NUM_COMP-1:0]            flag;
    logic                           ovf_flag;
    logic                           tick;
    logic                           running;
`ifdef TIMER_CAPTURE_EN
    logic                           cap_in;
    logic                           cap_clr;
    logic [CNT_W-1:0]               cap_value;
    logic                           cap_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;

    timer_counter_core #(
        .NUM_COMP(NUM_COMP), .CNT_W(CNT_W), .PSC_W(PSC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .start        (start),
        .period       (period),
        .prescale     (prescale),
        .match_value  (match_value),
        .flag_clr     (flag_clr),
        .ovf_clr      (ovf_clr),
`ifdef TIMER_CAPTURE_EN
        .cap_in       (cap_in),
        .cap_clr      (cap_clr),
        .cap_value    (cap_value),
        .cap_flag     (cap_flag),
`endif
        .counter_value(counter_value),
        .flag         (flag),
        .ovf_flag     (ovf_flag),
        .tick         (tick),
        .running      (running)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt4[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int exp_ovf4[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    int exp_f14[8]  = '{0, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'b00; start = 1'b0;
        period = 8'd4; prescale = 8'd0;
        match_value[0] = 8'hFF; match_value[1] = 8'hFF; match_value[2] = 8'hFF;
        flag_clr = '0; ovf_clr = 1'b0;
`ifdef TIMER_CAPTURE_EN
        cap_in = 1'b0; cap_clr = 1'b0;
`endif
        repeat (2) step_clk();
        check_val("rst_cnt", 32'(counter_value), 0);
        check_val("rst_flag", 32'(flag), 0);
        check_val("rst_ovf", 32'(ovf_flag), 0);
        check_val("rst_tick", 32'(tick), 0);
        check_val("rst_run", 32'(running), 0);

        // Free-run, prescale 0, period 4
        rst = 1'b1; en = 1'b1;
        #1;
        check_val("free_run", 32'(running), 1);
        for (int k = 1; k <= 5; k++) begin
            step_clk();
            check_val("free_cnt", 32'(counter_value), 32'(k % 5));
            check_val("free_tick", 32'(tick), 1);
            check_val("free_ovf", 32'(ovf_flag), (k == 5) ? 1 : 0);
        end
        step_clk();
        check_val("free_cnt6", 32'(counter_value), 1);
        en = 1'b0;
        repeat (3) step_clk();
        check_val("hold_cnt", 32'(counter_value), 1);
        check_val("hold_tick", 32'(tick), 0);
        check_val("hold_run", 32'(running), 0);

        // Prescale 2, period 2, match channel 0 at 2
        rst = 1'b0; prescale = 8'd2; period = 8'd2; match_value[0] = 8'd2;
        step_clk();
        rst = 1'b1; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            check_val("psc_cnt", 32'(counter_value), 32'((k / 3) % 3));
            check_val("psc_tick", 32'(tick), (k % 3 == 0) ? 1 : 0);
            if (k == 5)  check_val("psc_f0_pre", 32'(flag[0]), 0);
            if (k == 6)  check_val("psc_f0_set", 32'(flag[0]), 1);
            if (k == 8)  check_val("psc_ovf_pre", 32'(ovf_flag), 0);
            if (k == 9)  check_val("psc_ovf_set", 32'(ovf_flag), 1);
            if (k == 12) check_val("psc_f0_stick", 32'(flag[0]), 1);
        end
        flag_clr = 3'b001; ovf_clr = 1'b1;
        step_clk();
        flag_clr = '0; ovf_clr = 1'b0;
        check_val("f0_clr", 32'(flag[0]), 0);
        check_val("ovf_clr", 32'(ovf_flag), 0);

        // One-shot, period 3
        mode = 2'b01; period = 8'd3; prescale = 8'd0;
        step_clk();
        check_val("os_chg_cnt", 32'(counter_value), 0);
        check_val("os_idle_run", 32'(running), 0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check_val("os_armed_run", 32'(running), 1);
        check_val("os_armed_cnt", 32'(counter_value), 0);
        for (int k = 1; k <= 4; k++) begin
            step_clk();
            check_val("os_cnt", 32'(counter_value), 32'(k % 4));
        end
        check_val("os_done_run", 32'(running), 0);
        check_val("os_ovf", 32'(ovf_flag), 1);
        repeat (2) step_clk();
        check_val("os_hold_cnt", 32'(counter_value), 0);
        check_val("os_hold_tick", 32'(tick), 0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        step_clk();
        check_val("os2_cnt1", 32'(counter_value), 1);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check_val("os2_cnt2", 32'(counter_value), 2);
        step_clk();
        check_val("os2_cnt3", 32'(counter_value), 3);
        step_clk();
        check_val("os2_cnt0", 32'(counter_value), 0);
        check_val("os2_run", 32'(running), 0);

        // Up-down, period 3; flag[1] clear-vs-set on channel 1 match at 2
        mode = 2'b10; ovf_clr = 1'b1; flag_clr = 3'b111; match_value[1] = 8'd2;
        step_clk();
        ovf_clr = 1'b0; flag_clr = '0;
        check_val("ud_chg_cnt", 32'(counter_value), 0);
        check_val("ud_chg_f1", 32'(flag[1]), 0);
        for (int i = 0; i < 8; i++) begin
            flag_clr = (i == 2 || i == 3) ? 3'b010 : 3'b000;
            step_clk();
            check_val("ud_cnt", 32'(counter_value), 32'(exp_cnt4[i]));
            check_val("ud_ovf", 32'(ovf_flag), 32'(exp_ovf4[i]));
            check_val("ud_f1", 32'(flag[1]), 32'(exp_f14[i]));
        end
        flag_clr = '0;

        // Reset mid-count, off a step boundary
        prescale = 8'd2;
        step_clk();
        check_val("mid_cnt", 32'(counter_value), 2);
        rst = 1'b0;
        step_clk();
        check_val("mid_rst_cnt", 32'(counter_value), 0);
        check_val("mid_rst_flag", 32'(flag), 0);
        check_val("mid_rst_ovf", 32'(ovf_flag), 0);
        check_val("mid_rst_tick", 32'(tick), 0);
        check_val("mid_rst_run", 32'(running), 0);
        rst = 1'b1;

        // Reserved mode holds
        mode = 2'b11; prescale = 8'd0;
        repeat (4) step_clk();
        check_val("m11_cnt", 32'(counter_value), 0);
        check_val("m11_run", 32'(running), 0);

`ifdef TIMER_CAPTURE_EN
        rst = 1'b0; mode = 2'b00; prescale = 8'd3; period = 8'd20;
        step_clk();
        check_val("cap_rst_val", 32'(cap_value), 0);
        check_val("cap_rst_flag", 32'(cap_flag), 0);
        rst = 1'b1;
        repeat (20) step_clk();
        check_val("cap_cnt5", 32'(counter_value), 5);
        cap_in = 1'b1;
        repeat (3) step_clk();
        check_val("cap_val", 32'(cap_value), 5);
        check_val("cap_flag", 32'(cap_flag), 1);
        cap_clr = 1'b1;
        step_clk();
        cap_clr = 1'b0;
        check_val("cap_clr", 32'(cap_flag), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
